// File: rtl/split_14out_pkg.sv
// rtl/split_14out_pkg.sv - shared constants, destination type and decode helpers
// Contents:
//   NOUT, DEST_W   channel count and destination field width
//   dest_t         destination field type
//   is_legal_dest  true when a destination maps to an existing channel
//   dest_onehot    channel valid vector for a destination (all zero if illegal)
package split_pkg;

  localparam int NOUT   = 14;
  localparam int DEST_W = 4;

  typedef logic [DEST_W-1:0] dest_t;

  function automatic logic is_legal_dest(dest_t d);
    return d < DEST_W'(NOUT);
  endfunction

  function automatic logic [NOUT-1:0] dest_onehot(dest_t d);
    logic [NOUT-1:0] v;
    v = '0;
    if (is_legal_dest(d)) begin
      v[d] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/split_14out_if.sv
// rtl/split_14out_if.sv - input channel, 14 output channels and drop status bundle
// Signals:
//   in_valid/in_ready/in_data     single input channel
//   out_valid/out_ready/out_data  one-hot valid per channel, shared data bus
//   drop_pulse/drop_cnt           illegal-destination discard status
// Modports:
//   slave   router side
//   master  producer/consumer environment side
interface split_14out_if
  import split_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [NOUT-1:0]  out_valid;
  logic [NOUT-1:0]  out_ready;
  logic [WIDTH-1:0] out_data;
  logic             drop_pulse;
  logic [CNT_W-1:0] drop_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, drop_pulse, drop_cnt
  );

endinterface

// File: rtl/split_14out_fifo.sv
// rtl/split_14out_fifo.sv - DEPTH-entry register FIFO with occupancy count and flags
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, wdata  write request and data; ignored while full, even with a pop
//   pop          read request; ignored while empty
//   rdata        current head entry, combinational from storage
//   full, empty  occupancy flags
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
  function automatic logic [PW-1:0] ptr_next(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/split_14out.sv
// rtl/split_14out.sv - clocked 1-to-14 packet router with input FIFO and drop counter
// Ports:
//   clk     single clock, rising edge
//   rst_n   synchronous reset, active-low
//   bus     split_14out_if.slave: input channel, 14 output channels, drop status
// Parameters:
//   WIDTH, DEST_LSB  packet width and position of the 4-bit destination field
//   DEPTH            input FIFO entries (2..8)
//   CNT_W            dropped-packet counter width
module split_14out
  import split_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEST_LSB = 28,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  split_14out_if.slave  bus
);

  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;
  dest_t            dest;
  logic [NOUT-1:0]  out_valid;
  logic             drop_pulse;
  logic [CNT_W-1:0] drop_cnt;

  // in_ready depends only on FIFO occupancy, never on out_ready.
  assign bus.in_ready = rst_n && !full;
  assign push         = bus.in_valid && bus.in_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign dest = head[DEST_LSB +: DEST_W];

  // Legal head: present on its channel and wait for that consumer only.
  // Illegal head: never presented, discarded on the next edge.
  always_comb begin
    out_valid = '0;
    pop       = 1'b0;
    drop      = 1'b0;
    if (!empty) begin
      if (is_legal_dest(dest)) begin
        out_valid = dest_onehot(dest);
        pop       = bus.out_ready[dest];
      end else begin
        pop  = 1'b1;
        drop = 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign bus.drop_pulse = drop_pulse;
  assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_split_14out.sv
// tb/tb_split_14out.sv - directed self-checking bench for split_14out
module tb_split_14out;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  split_14out_if #(.WIDTH(32), .CNT_W(8)) bus ();

  split_14out #(
    .WIDTH    (32),
    .DEST_LSB (28),
    .DEPTH    (2),
    .CNT_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pkt(int d, int pay);
    logic [31:0] dv;
    logic [31:0] pv;
    dv = d;
    pv = pay;
    return {dv[3:0], pv[27:0]};
  endfunction

  function automatic logic [13:0] oh(int d);
    logic [13:0] one;
    one = 14'd1;
    return one << d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = '1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 14'h0) begin
      errors++;
      $display("FAIL reset_out_valid: got %h expected 0", bus.out_valid);
    end
    checks++;
    if (bus.drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop_pulse: got %b expected 0", bus.drop_pulse);
    end
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bus.out_ready = '1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5000_00AA;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 14'h0020) begin
      errors++;
      $display("FAIL single_out_valid: got %h expected 0020", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 32'h5000_00AA) begin
      errors++;
      $display("FAIL single_out_data: got %h expected 500000aa", bus.out_data);
    end
    tick();
    checks++;
    if (bus.out_valid !== 14'h0) begin
      errors++;
      $display("FAIL single_empty_after: got %h expected 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = pkt(3, 'h11);
    tick();
    bus.in_data = pkt(7, 'h22);
    tick();
    bus.in_data = pkt(9, 'h33);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== oh(3) || bus.out_data !== pkt(3, 'h11)) begin
      errors++;
      $display("FAIL bp_head3: got %h/%h expected %h/%h", bus.out_valid, bus.out_data, oh(3), pkt(3, 'h11));
    end
    tick();
    checks++;
    if (bus.out_valid !== oh(3) || bus.out_data !== pkt(3, 'h11)) begin
      errors++;
      $display("FAIL bp_head3_stable: got %h/%h expected %h/%h", bus.out_valid, bus.out_data, oh(3), pkt(3, 'h11));
    end
    bus.out_ready = oh(3);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_comb_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== oh(7) || bus.out_data !== pkt(7, 'h22)) begin
      errors++;
      $display("FAIL bp_head7: got %h/%h expected %h/%h", bus.out_valid, bus.out_data, oh(7), pkt(7, 'h22));
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after_pop: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== oh(7) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_9_accepted: got valid %h ready %b expected %h ready 0", bus.out_valid, bus.in_ready, oh(7));
    end
    bus.out_ready = '1;
    tick();
    checks++;
    if (bus.out_valid !== oh(9) || bus.out_data !== pkt(9, 'h33)) begin
      errors++;
      $display("FAIL bp_head9: got %h/%h expected %h/%h", bus.out_valid, bus.out_data, oh(9), pkt(9, 'h33));
    end
    tick();
    checks++;
    if (bus.out_valid !== 14'h0) begin
      errors++;
      $display("FAIL bp_empty: got %h expected 0", bus.out_valid);
    end
  endtask

  task automatic test_drop();
    int pulses;
    pulses        = 0;
    bus.out_ready = '1;
    bus.in_valid  = 1'b1;
    bus.in_data   = pkt(14, 'h1);
    tick();
    bus.in_data = pkt(15, 'h2);
    #1;
    checks++;
    if (bus.out_valid !== 14'h0 || bus.drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL drop_first_cycle: got valid %h pulse %b expected 0/0", bus.out_valid, bus.drop_pulse);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    if (bus.drop_pulse === 1'b1) pulses++;
    checks++;
    if (bus.drop_cnt !== 8'd1 || bus.out_valid !== 14'h0) begin
      errors++;
      $display("FAIL drop_cnt1: got cnt %0d valid %h expected 1/0", bus.drop_cnt, bus.out_valid);
    end
    tick();
    if (bus.drop_pulse === 1'b1) pulses++;
    tick();
    if (bus.drop_pulse === 1'b1) pulses++;
    tick();
    if (bus.drop_pulse === 1'b1) pulses++;
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL drop_pulse_cycles: got %0d expected 2", pulses);
    end
    checks++;
    if (bus.drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL drop_cnt2: got %0d expected 2", bus.drop_cnt);
    end
  endtask

  task automatic test_stream();
    int recv [14];
    int exp_n;
    int bad;
    logic [31:0] exp_d;
    do_reset();
    bad = 0;
    for (int ch = 0; ch < 14; ch++) recv[ch] = 0;
    for (int c = 0; c <= 301; c++) begin
      if (c < 300) begin
        bus.in_valid = 1'b1;
        bus.in_data  = pkt(c % 14, c);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c >= 1 && c <= 300) begin
        exp_d = pkt((c - 1) % 14, c - 1);
        checks++;
        if (bus.out_valid !== oh((c - 1) % 14) || bus.out_data !== exp_d || bus.in_ready !== 1'b1) begin
          errors++;
          bad++;
          if (bad < 5)
            $display("FAIL stream_pkt%0d: got %h/%h rdy %b expected %h/%h rdy 1", c - 1, bus.out_valid, bus.out_data, bus.in_ready, oh((c - 1) % 14), exp_d);
        end else begin
          recv[(c - 1) % 14]++;
        end
      end else if (c == 301) begin
        checks++;
        if (bus.out_valid !== 14'h0) begin
          errors++;
          $display("FAIL stream_drained: got %h expected 0", bus.out_valid);
        end
      end
      tick();
    end
    for (int ch = 0; ch < 14; ch++) begin
      exp_n = (ch < 6) ? 22 : 21;
      checks++;
      if (recv[ch] != exp_n) begin
        errors++;
        $display("FAIL stream_ch%0d_count: got %0d expected %0d", ch, recv[ch], exp_n);
      end
    end
    checks++;
    if (bus.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stream_drop_cnt: got %0d expected 0", bus.drop_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.out_ready = '0;
    for (int k = 0; k < 260; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pkt(15, k);
      tick();
      if (k == 99) begin
        checks++;
        if (bus.drop_cnt !== 8'd99 || bus.drop_pulse !== 1'b1) begin
          errors++;
          $display("FAIL sat_mid: got cnt %0d pulse %b expected 99/1", bus.drop_cnt, bus.drop_pulse);
        end
      end
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt: got %0d expected 255", bus.drop_cnt);
    end
    checks++;
    if (bus.drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL sat_pulse_idle: got %b expected 0", bus.drop_pulse);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = pkt(2, 'hA);
    tick();
    bus.in_data = pkt(2, 'hB);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== oh(2)) begin
      errors++;
      $display("FAIL rmid_full: got rdy %b valid %h expected 0/%h", bus.in_ready, bus.out_valid, oh(2));
    end
    rst_n         = 1'b0;
    bus.out_ready = '1;
    tick();
    checks++;
    if (bus.out_valid !== 14'h0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_in_reset: got valid %h rdy %b expected 0/0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_release_ready: got %b expected 1", bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.out_valid !== 14'h0) begin
        errors++;
        $display("FAIL rmid_stale%0d: got %h expected 0", k, bus.out_valid);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = pkt(4, 'hC);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== oh(4) || bus.out_data !== pkt(4, 'hC)) begin
      errors++;
      $display("FAIL rmid_fresh: got %h/%h expected %h/%h", bus.out_valid, bus.out_data, oh(4), pkt(4, 'hC));
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_drop();
    test_stream();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
